// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if : single-outstanding request/acknowledge data-memory bus.
//
// Signals
//   bus_req   : request, held high until acknowledged
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word-aligned byte address
//   bus_be    : byte-lane enables
//   bus_wdata : lane-replicated write data (0 on reads)
//   bus_rdata : read data, valid while bus_ack = 1
//   bus_ack   : one-cycle acknowledge
//
// Modports
//   master : the load/store unit (drives the request side)
//   slave  : the memory (drives rdata/ack)
// ---------------------------------------------------------------------------
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store unit sitting behind the instruction decoder.
//
// Takes the decoded memory controls, funct3 (RV32I size/signedness), the ALU
// effective address and rs2 store data, and runs one access at a time on the
// request/acknowledge data bus. Loads are lane-selected and sign/zero
// extended. Misaligned, illegal and timed-out accesses are reported as a
// one-cycle fault pulse with a reason code.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   mem_read_control   : load request
//   mem_write_control  : store request
//   funct3             : access size / signedness
//   addr               : effective byte address
//   store_data         : rs2 value for stores
//   load_data          : extended load result (held outside DONE)
//   load_valid         : one-cycle pulse with load_data
//   stall              : hold the upstream pipeline
//   fault, fault_code  : abort pulse and reason (01 misaligned, 10 timeout,
//                        11 illegal)
//   bus                : data-memory bus, master side
//
// Parameter
//   TIMEOUT : BUS cycles without bus_ack before a timeout fault (1..65535)
// ---------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_control,
    input  logic        mem_write_control,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_code,
    lsu_if.master       bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_data_q, load_data_d;
    logic               load_ok_q, load_ok_d;
    logic [1:0]         fault_code_q, fault_code_d;

    logic               req_any;
    logic               illegal;
    logic               misaligned;

    // funct3[1:0]: 0 = byte, 1 = halfword, 2 = word
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'b0, b};
            3'd5:    return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    assign req_any = mem_read_control | mem_write_control;

    always_comb begin
        illegal = 1'b0;
        if (mem_read_control && mem_write_control) begin
            illegal = 1'b1;
        end else if (mem_read_control) begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end else if (mem_write_control) begin
            illegal = (funct3 > 3'd2);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_ok_d    = 1'b0;
        fault_code_d = FC_NONE;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (illegal) begin
                        fault_code_d = FC_ILLEGAL;
                        state_d      = S_DONE;
                    end else if (misaligned) begin
                        fault_code_d = FC_MISALIGN;
                        state_d      = S_DONE;
                    end else begin
                        addr_d   = addr;
                        funct3_d = funct3;
                        we_d     = mem_write_control;
                        be_d     = lane_be(funct3[1:0], addr[1:0]);
                        wdata_d  = mem_write_control ? lane_wdata(funct3[1:0], store_data) : 32'b0;
                        cnt_d    = '0;
                        state_d  = S_BUS;
                    end
                end
            end

            S_BUS: begin
                // An acknowledge in the same cycle as the timeout takes priority.
                if (bus.bus_ack) begin
                    if (!we_q) begin
                        load_data_d = load_extend(funct3_q, addr_q[1:0], bus.bus_rdata);
                        load_ok_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fault_code_d = FC_TIMEOUT;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_ok_q    <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_ok_q    <= load_ok_d;
            fault_code_q <= fault_code_d;
        end
    end

    // load_ok_q and fault_code_q are only ever non-zero during DONE, so they
    // drive the one-cycle pulses directly.
    assign load_valid = load_ok_q;
    assign fault      = (fault_code_q != FC_NONE);
    assign fault_code = fault_code_q;
    assign load_data  = load_data_q;

    // rst_n gates stall so it drops immediately on reset even while decode
    // still presents a request.
    assign stall = rst_n && (((state_q == S_IDLE) && req_any) || (state_q == S_BUS));

    assign bus.bus_req   = (state_q == S_BUS);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule
